// File: rtl/figan_pkg.sv
// figan_pkg: fixed-point defaults and rounding/saturation helpers shared by every
// generator layer so they all quantise identically.
package figan_pkg;

  localparam int FIGAN_DATA_WIDTH = 16;
  localparam int FIGAN_FRAC_BITS  = 8;

  // Clamp a wide signed value into the range of a dw-bit signed word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int dw);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (dw - 1));
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
  endfunction

  // Half an LSB of the result, added before the final arithmetic shift.
  function automatic logic signed [63:0] round_const(input int frac);
    return (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
  endfunction

endpackage

// File: rtl/line_buffer_2d.sv
// line_buffer_2d: one image row of storage; synchronous write, combinational read
// at the same address so a column can be read and replaced in one cycle.
module line_buffer_2d #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/conv3x3_stream_2d.sv
// conv3x3_stream_2d: streaming valid-mode 3x3 convolution with valid/ready on both sides.
// Define RELU_EN to replace negative saturated results with zero.
module conv3x3_stream_2d
  import figan_pkg::*;
#(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int DATA_WIDTH = FIGAN_DATA_WIDTH,
  parameter int FRAC_BITS  = FIGAN_FRAC_BITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic                    ready_in,
  input  logic [9*DATA_WIDTH-1:0] weights,
  input  logic [DATA_WIDTH-1:0]   bias,
  output logic                    valid_out,
  output logic [DATA_WIDTH-1:0]   data_out,
  input  logic                    ready_out
);

  localparam int DW    = DATA_WIDTH;
  localparam int PW    = 2 * DW;
  localparam int ACC_W = 2 * DW + 4;
  localparam int CW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(round_const(FRAC_BITS));

  logic                    adv;
  logic                    accept;
  logic                    complete;
  logic [CW-1:0]           col_cnt;
  logic [RW-1:0]           row_cnt;
  logic [DW-1:0]           lb0_q;
  logic [DW-1:0]           lb1_q;
  logic signed [DW-1:0]    win     [9];
  logic signed [DW-1:0]    win_nxt [9];
  logic signed [PW-1:0]    prod    [9];
  logic                    s1_valid;
  logic signed [ACC_W-1:0] acc;
  logic [DW-1:0]           result;

  assign adv      = !valid_out || ready_out;
  assign ready_in = adv;
  assign accept   = valid_in && adv;
  assign complete = (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));

  line_buffer_2d #(.DEPTH(IMG_WIDTH), .WIDTH(DW)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_cnt),
    .wdata (data_in),
    .rdata (lb0_q)
  );

  line_buffer_2d #(.DEPTH(IMG_WIDTH), .WIDTH(DW)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_cnt),
    .wdata (lb0_q),
    .rdata (lb1_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (col_cnt == COL_LAST) begin
        col_cnt <= '0;
        row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + RW'(1);
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end
  end

  // Window as it will look after this pixel; stage 1 multiplies it directly so the
  // completing pixel reaches valid_out two advances later.
  always_comb begin
    for (int ky = 0; ky < 3; ky++) begin
      win_nxt[3*ky]   = win[3*ky+1];
      win_nxt[3*ky+1] = win[3*ky+2];
    end
    win_nxt[2] = $signed(lb1_q);
    win_nxt[5] = $signed(lb0_q);
    win_nxt[8] = $signed(data_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) win[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < 9; k++) win[k] <= win_nxt[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      for (int k = 0; k < 9; k++) prod[k] <= '0;
    end else if (adv) begin
      s1_valid <= accept && complete;
      if (accept) begin
        for (int k = 0; k < 9; k++)
          prod[k] <= win_nxt[k] * $signed(weights[k*DW +: DW]);
      end
    end
  end

  always_comb begin
    acc = ROUND + (ACC_W'($signed(bias)) <<< FRAC_BITS);
    for (int k = 0; k < 9; k++) acc = acc + ACC_W'(prod[k]);
    result = DW'(saturate(64'(acc >>> FRAC_BITS), DW));
`ifdef RELU_EN
    if (result[DW-1]) result = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (adv) begin
      valid_out <= s1_valid;
      if (s1_valid) data_out <= result;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream_2d.sv
// tb_conv3x3_stream_2d: 6x6 frames checked against a direct 2D convolution model
// computed from the whole image; covers latency, stalls, saturation and reset.
module tb_conv3x3_stream_2d;

  localparam int W  = 6;
  localparam int H  = 6;
  localparam int DW = 16;
  localparam int FB = 8;
  localparam int MAX_CYCLES = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0;
  logic ready_out = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] bias = '0;
  logic [9*DW-1:0] weights = '0;
  logic ready_in;
  logic valid_out;
  logic [DW-1:0] data_out;

  int checks = 0;
  int passed = 0;
  int fails = 0;
  int img [H][W];
  int kern [9];
  int bias_v;
  int exp_q [$];
  int first_out_cycle;
  int out_count;

  always #5 clk = ~clk;

  conv3x3_stream_2d #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .DATA_WIDTH (DW),
    .FRAC_BITS  (FB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .weights   (weights),
    .bias      (bias),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ready_out (ready_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain Q8.8 arithmetic on the full image with a 3x3 window at (r, c).
  function automatic int ref_pixel(int r, int c);
    longint sum;
    sum = 0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        sum += longint'(img[r+ky][c+kx]) * longint'(kern[3*ky+kx]);
    sum += longint'(bias_v) * (64'sd1 <<< FB);
    sum += (64'sd1 <<< (FB - 1));
    sum = sum >>> FB;
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
`ifdef RELU_EN
    if (sum < 0) sum = 0;
`endif
    return int'(sum);
  endfunction

  task automatic loadModel();
    exp_q.delete();
    for (int r = 0; r < H - 2; r++)
      for (int c = 0; c < W - 2; c++)
        exp_q.push_back(ref_pixel(r, c));
    for (int k = 0; k < 9; k++) weights[k*DW +: DW] = DW'(kern[k]);
    bias = DW'(bias_v);
  endtask

  function automatic logic [31:0] word(input int v);
    logic [DW-1:0] t;
    t = DW'(v);
    return 32'(t);
  endfunction

  task automatic applyStimulus(input bit rand_ready);
    int pix;
    int cycle;
    int total;
    logic prev_stall;
    logic [DW-1:0] prev_data;
    pix = 0;
    cycle = 0;
    out_count = 0;
    first_out_cycle = -1;
    prev_stall = 1'b0;
    prev_data = '0;
    total = exp_q.size();
    while ((pix < W*H || exp_q.size() > 0) && cycle < MAX_CYCLES) begin
      @(negedge clk);
      ready_out = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      valid_in  = (pix < W*H);
      data_in   = valid_in ? DW'(img[pix/W][pix%W]) : '0;
      #1;
      checkOutput("ready_in", 32'(ready_in), 32'(!valid_out || ready_out));
      if (prev_stall) begin
        checkOutput("stall_valid", 32'(valid_out), 32'd1);
        checkOutput("stall_data", 32'(data_out), 32'(prev_data));
      end
      if (valid_out && ready_out) begin
        if (first_out_cycle < 0) first_out_cycle = cycle;
        if (exp_q.size() > 0) checkOutput("data_out", 32'(data_out), word(exp_q.pop_front()));
        else checkOutput("extra_output", 32'(out_count + 1), 32'(total));
        out_count++;
      end
      prev_stall = valid_out && !ready_out;
      prev_data  = data_out;
      if (valid_in && ready_in) pix++;
      cycle++;
    end
    checkOutput("pixels_sent", 32'(pix), 32'(W*H));
    checkOutput("pending_outputs", 32'(exp_q.size()), 32'd0);
    checkOutput("out_count", 32'(out_count), 32'(total));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_in  = 1'b0;
      ready_out = 1'b1;
      #1;
      checkOutput("drain_valid", 32'(valid_out), 32'd0);
    end
  endtask

  function automatic int rnd(int lo, int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_valid_out", 32'(valid_out), 32'd0);
    checkOutput("rst_data_out", 32'(data_out), 32'd0);
    checkOutput("rst_ready_in", 32'(ready_in), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Identity kernel: output (r,c) equals input (r+1,c+1).
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = (r*W + c) * 256;
    for (int k = 0; k < 9; k++) kern[k] = (k == 4) ? 256 : 0;
    bias_v = 0;
    loadModel();
    checkOutput("model_identity_first", word(exp_q[0]), word(7*256));
    applyStimulus(1'b0);
    checkOutput("latency", 32'(first_out_cycle), 32'(2*W + 2 + 2));

    // All-ones kernel with unit bias on a unit image gives 10.0.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 256;
    for (int k = 0; k < 9; k++) kern[k] = 256;
    bias_v = 256;
    loadModel();
    applyStimulus(1'b0);

    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 32767;
    for (int k = 0; k < 9; k++) kern[k] = 32767;
    bias_v = 0;
    loadModel();
    applyStimulus(1'b0);

    for (int k = 0; k < 9; k++) kern[k] = -32767;
    loadModel();
    applyStimulus(1'b1);

    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) img[r][c] = rnd(-4096, 4095);
      for (int k = 0; k < 9; k++) kern[k] = rnd(-512, 511);
      bias_v = rnd(-256, 255);
      loadModel();
      applyStimulus(1'b1);
    end

    // Zero-inserted 3x3 source: samples on even coordinates, zeros elsewhere.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = ((r % 2 == 0) && (c % 2 == 0)) ? rnd(-2048, 2047) : 0;
    for (int k = 0; k < 9; k++) kern[k] = rnd(-384, 383);
    bias_v = rnd(-128, 127);
    loadModel();
    applyStimulus(1'b1);

    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = rnd(-1024, 1023);
    for (int k = 0; k < 9; k++) kern[k] = rnd(-256, 255);
    bias_v = rnd(-64, 63);
    loadModel();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ready_out = 1'b1;
      valid_in  = 1'b1;
      data_in   = DW'(img[i/W][i%W]);
    end
    @(negedge clk);
    valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_valid_out", 32'(valid_out), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("midreset_hold_valid", 32'(valid_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
